matmul_result_serializer: RTL and testbench
===========================================

// Module: matmul_result_serializer
// PURPOSE
// - Output end of the 3x3 matmul datapath: snapshots the nine MAC accumulator results on a capture pulse,
//   then streams the active rows x cols sub-matrix out one element per beat, row-major, over valid/ready.
// - Mirrors the serial operand-load path at the input side: that path consumes data_in one nibble per clk;
//   this block produces results one word per accepted beat for a host or test harness.
// PARAMETERS
// - DIM   3   matrix dimension (MAC array is DIM x DIM)
// - ACC_W 10  width of one MAC accumulator result
// PORTS
// - clk        in   1            rising-edge clock
// - clear_n    in   1            asynchronous, active-low reset
// - capture    in   1            1-cycle pulse: MAC results are final, snapshot them
// - res_flat   in   DIM*DIM*ACC_W element (r,c) at bits [(r*DIM+c)*ACC_W +: ACC_W]
// - rows       in   2            active result rows (0..3), sampled with capture
// - cols       in   2            active result cols (0..3), sampled with capture
// - out_data   out  ACC_W        current result element
// - out_valid  out  1            out_data/out_last/out_idx are valid
// - out_ready  in   1            sink accepts beat when out_valid && out_ready
// - out_last   out  1            final element of the snapshot
// - out_idx    out  4            linear index r*DIM+c of current element
// - busy       out  1            snapshot held, stream in progress
// - done       out  1            1-cycle pulse after last beat accepted (or empty snapshot)
// BEHAVIOUR
// - Reset (clear_n=0, async): state IDLE; out_data=0, out_valid=0, out_last=0, out_idx=0, busy=0, done=0,
//   shadow registers and r/c counters cleared. Reset mid-stream aborts it; no done pulse.
// - FSM IDLE -> SEND -> DONE -> IDLE.
//   IDLE: on capture, latch res_flat into DIM*DIM shadow regs, latch rows/cols (values >DIM clamp to DIM),
//     r=c=0. If latched rows==0 or cols==0 -> DONE directly (no beats). Else -> SEND.
//   SEND: out_valid=1, out_data=shadow[r][c], out_idx=r*DIM+c, out_last=(r==rows-1 && c==cols-1).
//     On accept: if out_last -> DONE; else c+1, wrapping to 0 with r+1 at c==cols-1.
//   DONE: done=1 for exactly one cycle, out_valid=0, -> IDLE.
// - Latency: capture high at edge N -> out_valid high after edge N+1; one beat per cycle while out_ready=1.
// - Handshake: out_valid never drops and out_data/out_idx/out_last never change while out_valid && !out_ready.
// - busy=1 in SEND and DONE. capture while busy is ignored (snapshot not overwritten).
// - capture in the same cycle as DONE is ignored; accepted only in IDLE.
// - Shadow regs are the only source of out_data: res_flat may change freely after capture.
// - Results are unsigned ACC_W; no arithmetic performed, no truncation.
// - Beat count per snapshot = rows*cols (max 9); out_idx skips inactive columns (e.g. 2x2: 0,1,3,4).
// CONFIGURATION
// - MATMUL_SER_PARITY_EN defined: extra output port out_parity (1 bit) = even parity (XOR reduce) of out_data,
//   registered with out_data, same valid/hold rules, 0 at reset.
// - Not defined: port absent; all other behaviour identical.
// TESTING
// - Full 3x3: res elements 1..9, rows=cols=3, out_ready=1 -> 9 beats on consecutive cycles data 1..9,
//   idx 0..8, out_last only on data 9, done pulse the cycle after.
// - 2x2 sub-matrix: rows=cols=2, elements (r,c)=10*r+c -> beats 0,1,10,11, idx 0,1,3,4, last on 11.
// - Backpressure: out_ready low 3 cycles at beat 4 -> out_valid stays 1, out_data/idx/last stable, resumes with beat 5.
// - Empty: rows=0, cols=3 capture -> no out_valid, done pulses after edge N+1; capture during busy ignored,
//   stream of first snapshot unchanged; max value 1023 streamed unaltered.
// - Async reset: assert clear_n low mid-beat 5 between edges -> all outputs 0 immediately, no done;
//   new capture after release streams from idx 0.
// - MATMUL_SER_PARITY_EN build: out_data 0x3FF -> out_parity 0, 0x001 -> 1; held stable under backpressure.

Source files
------------

// File: rtl/matmul_result_serializer.sv
// rtl/matmul_result_serializer.sv - snapshots DIMxDIM MAC results and streams the active sub-matrix row-major
// Optional out_parity port enabled by defining MATMUL_SER_PARITY_EN.
module matmul_result_serializer #(
    parameter int DIM   = 3,
    parameter int ACC_W = 10
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     capture,
    input  logic [DIM*DIM*ACC_W-1:0] res_flat,
    input  logic [1:0]               rows,
    input  logic [1:0]               cols,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [3:0]               out_idx,
    output logic                     busy,
    output logic                     done
`ifdef MATMUL_SER_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] shadow [DIM*DIM];
    logic [1:0]       rows_q;
    logic [1:0]       cols_q;
    logic [1:0]       rows_cl;
    logic [1:0]       cols_cl;
    logic [1:0]       r;
    logic [1:0]       c;
    logic             cap_q;
    logic             take;
    logic             accept;
    logic             row_end;
    logic             at_last;
    logic [3:0]       idx;

    always_comb begin
        rows_cl = rows;
        cols_cl = cols;
        if (int'(rows) > DIM) rows_cl = 2'(DIM);
        if (int'(cols) > DIM) cols_cl = 2'(DIM);
    end

    // cap_q gives the snapshot one cycle to settle before the FSM leaves IDLE,
    // so the first beat (or the empty-snapshot done) appears one edge after capture.
    assign take    = capture && (state == IDLE) && !cap_q;
    assign idx     = 4'(int'(r) * DIM + int'(c));
    assign row_end = (c == cols_q - 2'd1);
    assign at_last = row_end && (r == rows_q - 2'd1);
    assign accept  = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cap_q) begin
                    state_nxt = ((rows_q == 2'd0) || (cols_q == 2'd0)) ? DONE : SEND;
                end
            end
            SEND: begin
                if (accept && at_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cap_q  <= 1'b0;
            rows_q <= 2'd0;
            cols_q <= 2'd0;
            r      <= 2'd0;
            c      <= 2'd0;
            for (int i = 0; i < DIM * DIM; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            cap_q <= take;
            if (take) begin
                for (int i = 0; i < DIM * DIM; i++) begin
                    shadow[i] <= res_flat[i*ACC_W +: ACC_W];
                end
                rows_q <= rows_cl;
                cols_q <= cols_cl;
                r      <= 2'd0;
                c      <= 2'd0;
            end else if (accept && !at_last) begin
                if (row_end) begin
                    c <= 2'd0;
                    r <= r + 2'd1;
                end else begin
                    c <= c + 2'd1;
                end
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_idx   = 4'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            SEND: begin
                out_valid = 1'b1;
                out_data  = shadow[idx];
                out_idx   = idx;
                out_last  = at_last;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MATMUL_SER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_matmul_result_serializer.sv
// tb/tb_matmul_result_serializer.sv - randomized bench with queue-based reference model for matmul_result_serializer
module tb_matmul_result_serializer;

    localparam int DIM   = 3;
    localparam int ACC_W = 10;

    logic                     clk       = 1'b0;
    logic                     clear_n   = 1'b0;
    logic                     capture   = 1'b0;
    logic                     out_ready = 1'b0;
    logic [1:0]               rows      = 2'd0;
    logic [1:0]               cols      = 2'd0;
    logic [DIM*DIM*ACC_W-1:0] res_flat  = '0;
    logic [ACC_W-1:0]         out_data;
    logic                     out_valid;
    logic                     out_last;
    logic [3:0]               out_idx;
    logic                     busy;
    logic                     done;
`ifdef MATMUL_SER_PARITY_EN
    logic                     out_parity;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int exp_data[$];
    int exp_idx[$];
    int exp_last[$];

    always #5 clk = ~clk;

    matmul_result_serializer #(.DIM(DIM), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .capture   (capture),
        .res_flat  (res_flat),
        .rows      (rows),
        .cols      (cols),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
`ifdef MATMUL_SER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected beat list: every active (r,c) in row-major order.
    function automatic void build_model(input int nr, input int nc, input int vals[9]);
        exp_data.delete();
        exp_idx.delete();
        exp_last.delete();
        for (int rr = 0; rr < nr; rr++) begin
            for (int cc = 0; cc < nc; cc++) begin
                exp_data.push_back(vals[rr*DIM+cc]);
                exp_idx.push_back(rr*DIM+cc);
                exp_last.push_back((rr == nr-1) && (cc == nc-1));
            end
        end
    endfunction

    task automatic scramble_res();
        for (int i = 0; i < DIM*DIM; i++) res_flat[i*ACC_W +: ACC_W] = ACC_W'($urandom());
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles on beat index 4
    task automatic run_snapshot(input int nr, input int nc, input int vals[9], input int mode, input bit busy_cap);
        int beat = 0;
        int low  = 0;
        int cyc  = 0;
        logic [31:0] nrv;
        logic [31:0] ncv;
        nrv = nr;
        ncv = nc;
        build_model(nr, nc, vals);
        rows = nrv[1:0];
        cols = ncv[1:0];
        for (int i = 0; i < DIM*DIM; i++) res_flat[i*ACC_W +: ACC_W] = ACC_W'(vals[i]);
        capture = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        scramble_res();
        chk("lat_valid_low", out_valid, 0);
        chk("lat_done_low", done, 0);
        @(posedge clk); #1;
        while (exp_data.size() > 0 && cyc < 300) begin
            chk("valid", out_valid, 1);
            chk("data", out_data, exp_data[0]);
            chk("idx", out_idx, exp_idx[0]);
            chk("last", out_last, exp_last[0]);
            chk("busy_send", busy, 1);
`ifdef MATMUL_SER_PARITY_EN
            chk("parity", out_parity, ^exp_data[0]);
`endif
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = ($urandom_range(0, 99) < 65);
            else if (beat == 4 && low < 3) begin
                out_ready = 1'b0;
                low++;
            end else out_ready = 1'b1;
            if (busy_cap && beat == 1) begin
                capture = 1'b1;
                rows    = 2'd1;
                cols    = 2'd1;
                scramble_res();
            end
            @(posedge clk); #1;
            capture = 1'b0;
            if (out_ready) begin
                void'(exp_data.pop_front());
                void'(exp_idx.pop_front());
                void'(exp_last.pop_front());
                beat++;
            end
            cyc++;
        end
        if (cyc >= 300) chk("stream_timeout", 1, 0);
        chk("done_pulse", done, 1);
        chk("done_valid_low", out_valid, 0);
        chk("done_busy", busy, 1);
        capture = 1'b1;
        rows    = 2'd3;
        cols    = 2'd3;
        @(posedge clk); #1;
        capture = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        chk("cap_in_done_ignored", out_valid, 0);
        chk("idle_busy2", busy, 0);
        out_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
`ifdef MATMUL_SER_PARITY_EN
        chk({tag, "_parity"}, out_parity, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[9];
        int cyc;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 clear_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) v[i] = i + 1;
        build_model(3, 3, v);
        chk("model_full_count", exp_data.size(), 9);
        chk("model_full_lastdata", exp_data[8], 9);
        run_snapshot(3, 3, v, 0, 1'b0);

        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++) v[rr*3+cc] = 10*rr + cc;
        build_model(2, 2, v);
        chk("model_2x2_idx2", exp_idx[2], 3);
        chk("model_2x2_data3", exp_data[3], 11);
        run_snapshot(2, 2, v, 0, 1'b0);

        for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 1023);
        v[0] = 1;
        v[4] = 1023;
        run_snapshot(3, 3, v, 2, 1'b0);

        run_snapshot(0, 3, v, 0, 1'b0);
        run_snapshot(3, 2, v, 1, 1'b1);

        // Abort a stream with reset in the middle of beat index 4.
        for (int i = 0; i < 9; i++) v[i] = i + 100;
        rows = 2'd3;
        cols = 2'd3;
        for (int i = 0; i < DIM*DIM; i++) res_flat[i*ACC_W +: ACC_W] = ACC_W'(v[i]);
        capture = 1'b1;
        @(posedge clk); #1;
        capture   = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_idx == 4'd4) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reset_reach_beat5", out_idx, 4);
        #2 clear_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        chk("abort_no_done", done, 0);
        chk("abort_no_valid", out_valid, 0);
        clear_n   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        run_snapshot(3, 3, v, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 9; i++) v[i] = $urandom_range(0, 1023);
            run_snapshot($urandom_range(0, 3), $urandom_range(0, 3), v, 1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
